// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: controller state encoding.
package serial_sub_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/digit_subtractor.sv
// Combinational ripple subtractor for one DIGIT-wide slice: d = x - y - bin.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic w_borrow;

  always_comb begin
    w_borrow = bin;
    d        = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]     = x[i] ^ y[i] ^ w_borrow;
      w_borrow = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_borrow);
    end
    bout = w_borrow;
  end
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: a - b - b_in, one DIGIT slice per clock, LSB slice first,
// with valid/ready handshakes on both sides.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);
  import serial_sub_pkg::*;

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic               r_smode;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [WIDTH-1:0]   r_diff;
  logic               r_b_out;
  logic               r_ovf;
  logic               r_zero;
  logic [DIGIT-1:0]   w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_diff_next;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x    (r_a[DIGIT-1:0]),
    .y    (r_b[DIGIT-1:0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CNT_W'(NDIG - 1));
  // New slice enters at the top; after NDIG shifts the LSB slice lands at bit 0.
  assign w_diff_next = (r_diff >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_smode  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_b_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt    <= '0;
            r_a      <= a;
            r_b      <= b;
            r_borrow <= b_in;
            r_smode  <= signed_mode;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_diff   <= '0;
            r_b_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
          end
        end
        RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_borrow <= w_bout;
          r_diff   <= w_diff_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_b_out <= w_bout;
            r_ovf   <= r_smode & (r_a_msb != r_b_msb) & (w_diff_next[WIDTH-1] != r_a_msb);
            r_zero  <= (w_diff_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign b_out     = r_b_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=16, DIGIT=4) against an arithmetic model.
module tb_serial_subtractor;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              b_in = 1'b0;
  logic              signed_mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  diff;
  logic              b_out;
  logic              ovf;
  logic              zero;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .b_in        (b_in),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .b_out       (b_out),
    .ovf         (ovf),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  // {diff, b_out, ovf, zero} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin, input logic msm);
    int s;
    logic [15:0] d;
    logic bo, ov, z;
    s  = int'(ma) - int'(mb) - int'(mbin);
    d  = s[15:0];
    bo = (s < 0);
    ov = msm && (ma[15] != mb[15]) && (d[15] != ma[15]);
    z  = (d == 16'h0);
    return {d, bo, ov, z};
  endfunction

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input logic tsm);
    a = ta; b = tb_v; b_in = tbin; signed_mode = tsm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    b_in = 1'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, diff, b_out, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b vld=%b diff=%h bo=%b ovf=%b z=%b, want rdy=1 vld=0 diff=0000 bo=0 ovf=0 z=0",
               in_ready, out_valid, diff, b_out, ovf, zero);
    end
    rst = 1'b0;
    start_op(16'h00FF, 16'h0100, 1'b0, 1'b1);
    wait_done(lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, diff, b_out, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_in_done: got rdy=%b vld=%b diff=%h bo=%b ovf=%b z=%b, want reset values",
               in_ready, out_valid, diff, b_out, ovf, zero);
    end
  endtask

  typedef struct {
    logic [15:0] ta;
    logic [15:0] tb_v;
    logic        tbin;
    logic        tsm;
    logic [18:0] exp;
  } dcase_t;

  task automatic test_directed;
    dcase_t cases[7];
    int lat;
    cases[0] = '{16'h1234, 16'h0234, 1'b0, 1'b0, {16'h1000, 3'b000}};
    cases[1] = '{16'h0000, 16'h0001, 1'b0, 1'b0, {16'hFFFF, 3'b100}};
    cases[2] = '{16'h0005, 16'h0005, 1'b1, 1'b0, {16'hFFFF, 3'b100}};
    cases[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 3'b010}};
    cases[4] = '{16'h8000, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 3'b000}};
    cases[5] = '{16'h7777, 16'h7777, 1'b0, 1'b1, {16'h0000, 3'b001}};
    cases[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, {16'h8000, 3'b110}};
    for (int i = 0; i < 7; i++) begin
      start_op(cases[i].ta, cases[i].tb_v, cases[i].tbin, cases[i].tsm);
      wait_done(lat);
      vectors++;
      if (lat !== NDIG) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, NDIG);
      end
      vectors++;
      if ({diff, b_out, ovf, zero} !== cases[i].exp) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got diff=%h bo=%b ovf=%b z=%b, want diff=%h bo=%b ovf=%b z=%b",
                 i, diff, b_out, ovf, zero, cases[i].exp[18:3], cases[i].exp[2], cases[i].exp[1], cases[i].exp[0]);
      end
      release_out();
    end
  endtask

  task automatic test_hold;
    int lat;
    logic [18:0] exp;
    exp = model(16'h4321, 16'h1111, 1'b0, 1'b1);
    start_op(16'h4321, 16'h1111, 1'b0, 1'b1);
    wait_done(lat);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, diff, b_out, ovf, zero} !== {1'b1, 1'b0, exp}) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b diff=%h bo=%b ovf=%b z=%b, want vld=1 rdy=0 diff=%h",
                 c, out_valid, in_ready, diff, b_out, ovf, zero, exp[18:3]);
      end
    end
    release_out();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL hold_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int seen;
    logic [18:0] exp;
    start_op(16'h1234, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, diff, b_out, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b diff=%h bo=%b ovf=%b z=%b, want reset values",
               in_ready, out_valid, diff, b_out, ovf, zero);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midrun_no_valid: got %0d out_valid cycles, want 0", seen);
    end
    exp = model(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    start_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    wait_done(lat);
    vectors++;
    if (lat !== NDIG || {diff, b_out, ovf, zero} !== exp) begin
      miscompares++;
      $display("FAIL midrun_next_op: got lat=%0d diff=%h bo=%b ovf=%b z=%b, want lat=%0d diff=%h bo=%b ovf=%b z=%b",
               lat, diff, b_out, ovf, zero, NDIG, exp[18:3], exp[2], exp[1], exp[0]);
    end
    release_out();
  endtask

  task automatic test_random;
    int lat;
    logic [15:0] ra, rb;
    logic rbin, rsm;
    logic [18:0] exp;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if (i % 7 == 0) rb = ra;
      rbin = 1'($urandom); rsm = 1'($urandom);
      exp = model(ra, rb, rbin, rsm);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL random_ready[%0d]: got %b, want 1", i, in_ready);
      end
      start_op(ra, rb, rbin, rsm);
      wait_done(lat);
      vectors++;
      if (lat !== NDIG || {diff, b_out, ovf, zero} !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b sm=%b: got lat=%0d diff=%h bo=%b ovf=%b z=%b, want lat=%0d diff=%h bo=%b ovf=%b z=%b",
                 i, ra, rb, rbin, rsm, lat, diff, b_out, ovf, zero, NDIG, exp[18:3], exp[2], exp[1], exp[0]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      release_out();
    end
  endtask

  task automatic test_back_to_back;
    logic [18:0] q[$];
    logic [18:0] exp;
    int cyc, last_done, done_cnt;
    cyc = 0; last_done = -1; done_cnt = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (cyc < 80 && done_cnt < 6) begin
      a = 16'($urandom); b = 16'($urandom);
      b_in = 1'($urandom); signed_mode = 1'($urandom);
      if (in_ready === 1'b1) q.push_back(model(a, b, b_in, signed_mode));
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_unexpected: got result diff=%h with no pending op, want none", diff);
        end else begin
          exp = q.pop_front();
          if ({diff, b_out, ovf, zero} !== exp) begin
            miscompares++;
            $display("FAIL b2b_result[%0d]: got diff=%h bo=%b ovf=%b z=%b, want diff=%h bo=%b ovf=%b z=%b",
                     done_cnt, diff, b_out, ovf, zero, exp[18:3], exp[2], exp[1], exp[0]);
          end
        end
        if (last_done >= 0) begin
          vectors++;
          if (cyc - last_done !== NDIG + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", done_cnt, cyc - last_done, NDIG + 2);
          end
        end
        last_done = cyc;
        done_cnt++;
      end
    end
    vectors++;
    if (done_cnt !== 6) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, want 6", done_cnt);
    end
    in_valid = 1'b0;
    repeat (NDIG + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
